// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame geometry,
// used by both the slave and the master FSM.
package spi_pkg;

    localparam int unsigned SPI_F_SIZE = 8;
    localparam int unsigned SPI_F_NUM  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_slave_shifter.sv
// SPI slave datapath: rx/tx shift registers and bit index.
// clr_i clears everything asynchronously (reset or CS released).
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int unsigned F_SIZE = SPI_F_SIZE,
    parameter int unsigned C_SIZE = $clog2(F_SIZE)
) (
    input  logic              sclk_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              mosi_i,
    input  logic [F_SIZE-2:0] tx_lo_i,
    output logic [C_SIZE-1:0] bit_idx_o,
    output logic [F_SIZE-2:0] rx_part_o,
    output logic              tx_bit_o
);

    // Only F_SIZE-1 received bits need storing; the last bit comes straight from MOSI.
    localparam int unsigned RXW = F_SIZE - 1;

    logic [C_SIZE-1:0] bit_idx_q;
    logic [RXW-1:0]    rx_sr_q;
    logic [F_SIZE-1:0] tx_sr_q;
    logic              tx_bit_q;

    // Sample MOSI, advance bit index, load/shift tx word on rising SCLK.
    always_ff @(posedge sclk_i or posedge clr_i) begin
        if (clr_i) begin
            bit_idx_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
        end else if (en_i) begin
            rx_sr_q <= RXW'({rx_sr_q, mosi_i});
            if (bit_idx_q == '0) begin
                tx_sr_q <= {tx_lo_i, 1'b0};
            end else begin
                tx_sr_q <= {tx_sr_q[F_SIZE-2:0], 1'b0};
            end
            if (bit_idx_q == C_SIZE'(F_SIZE - 1)) begin
                bit_idx_q <= '0;
            end else begin
                bit_idx_q <= bit_idx_q + C_SIZE'(1);
            end
        end
    end

    // Present the next tx bit on falling SCLK so the master samples it on the rise.
    always_ff @(negedge sclk_i or posedge clr_i) begin
        if (clr_i) begin
            tx_bit_q <= 1'b0;
        end else begin
            tx_bit_q <= tx_sr_q[F_SIZE-1];
        end
    end

    assign bit_idx_o = bit_idx_q;
    assign rx_part_o = rx_sr_q;
    assign tx_bit_o  = tx_bit_q;

endmodule : spi_slave_shifter

// File: rtl/spi_slave.sv
// SPI mode-0 slave: FSM, frame counter and rx handshake around the shifter.
// Build option: define SPI_SLAVE_TRISTATE_EN to float MISO (instead of
// driving 0) while CS is high or the transfer is DONE.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned F_SIZE  = SPI_F_SIZE,
    parameter int unsigned F_NUM   = SPI_F_NUM,
    parameter int unsigned C_SIZE  = $clog2(F_SIZE),
    parameter int unsigned FC_SIZE = $clog2(F_NUM + 1)
) (
    input  logic               SCLK,
    input  logic               rst,
    input  logic               CS,
    input  logic               MOSI,
    output logic               MISO,
    input  logic [F_SIZE-1:0]  tx_data_i,
    output logic [F_SIZE-1:0]  rx_data_o,
    output logic               rx_valid_o,
    input  logic               rx_ack_i,
    output logic               overrun_o,
    output logic [FC_SIZE-1:0] frame_cnt_o,
    output logic               busy_o
);

    spi_state_e         state_q;
    logic [FC_SIZE-1:0] frame_cnt_q;
    logic               busy_q;
    logic [F_SIZE-1:0]  rx_data_q;
    logic               rx_valid_q;
    logic               overrun_q;

    logic [C_SIZE-1:0]  bit_idx;
    logic [F_SIZE-2:0]  rx_part;
    logic               tx_bit;

    logic               clr_c;
    logic               en_c;
    logic               frame_end_c;
    logic               release_c;
    logic [F_SIZE-1:0]  rx_word_c;

    // Transfer state is dropped whenever reset is asserted or CS is released.
    assign clr_c       = rst | CS;
    assign en_c        = (state_q != DONE);
    assign frame_end_c = en_c && !CS && (bit_idx == C_SIZE'(F_SIZE - 1));
    assign rx_word_c   = {rx_part, MOSI};
    assign release_c   = CS || (state_q == DONE);

    spi_slave_shifter #(
        .F_SIZE (F_SIZE),
        .C_SIZE (C_SIZE)
    ) u_shifter (
        .sclk_i    (SCLK),
        .clr_i     (clr_c),
        .en_i      (en_c),
        .mosi_i    (MOSI),
        .tx_lo_i   (tx_data_i[F_SIZE-2:0]),
        .bit_idx_o (bit_idx),
        .rx_part_o (rx_part),
        .tx_bit_o  (tx_bit)
    );

    // Transfer FSM and per-CS frame counter.
    always_ff @(posedge SCLK or posedge clr_c) begin
        if (clr_c) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= SHIFT;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    if (frame_end_c) begin
                        frame_cnt_q <= frame_cnt_q + FC_SIZE'(1);
                        if (frame_cnt_q == FC_SIZE'(F_NUM - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Receive handshake: survives CS release, cleared only by reset.
    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (frame_end_c) begin
            rx_data_q  <= rx_word_c;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !rx_ack_i) begin
                overrun_q <= 1'b1;
            end
        end else if (rx_ack_i) begin
            rx_valid_q <= 1'b0;
        end
    end

    // MISO: word MSB straight from tx_data_i at a frame boundary, shifter bit otherwise.
`ifdef SPI_SLAVE_TRISTATE_EN
    assign MISO = release_c ? 1'bz :
                  rst       ? 1'b0 :
                  (bit_idx == '0) ? tx_data_i[F_SIZE-1] : tx_bit;
`else
    assign MISO = release_c ? 1'b0 :
                  rst       ? 1'b0 :
                  (bit_idx == '0) ? tx_data_i[F_SIZE-1] : tx_bit;
`endif

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign overrun_o   = overrun_q;
    assign frame_cnt_o = frame_cnt_q;
    assign busy_o      = busy_q;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave (F_SIZE=8, F_NUM=2): bench acts as mode-0 master
// and tracks expected slave outputs with a word-level reference model.
module tb_spi_slave;

    localparam int unsigned FS  = 8;
    localparam int unsigned FN  = 2;
    localparam int unsigned FCS = $clog2(FN + 1);
`ifdef SPI_SLAVE_TRISTATE_EN
    localparam logic MISO_REL = 1'bz;
`else
    localparam logic MISO_REL = 1'b0;
`endif

    logic           SCLK;
    logic           rst;
    logic           CS;
    logic           MOSI;
    logic           MISO;
    logic [FS-1:0]  tx_data_i;
    logic [FS-1:0]  rx_data_o;
    logic           rx_valid_o;
    logic           rx_ack_i;
    logic           overrun_o;
    logic [FCS-1:0] frame_cnt_o;
    logic           busy_o;

    spi_slave #(
        .F_SIZE (FS),
        .F_NUM  (FN)
    ) dut (
        .SCLK        (SCLK),
        .rst         (rst),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .tx_data_i   (tx_data_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ack_i    (rx_ack_i),
        .overrun_o   (overrun_o),
        .frame_cnt_o (frame_cnt_o),
        .busy_o      (busy_o)
    );

    int n_checks;
    int n_fail;

    // Reference model: what the consumer should see.
    logic [FS-1:0] m_word;
    logic [FS-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;
    logic          m_started;
    int            m_cnt;
    int            m_bits;

    task automatic model_reset();
        m_word = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        m_started = 1'b0; m_cnt = 0; m_bits = 0;
    endtask

    // One SCLK period as the master; returns MISO as seen at the rising edge.
    task automatic clk_edge(input logic mosi_b, input logic ack, output logic miso_b);
        logic done_f;
        MOSI = mosi_b;
        rx_ack_i = ack;
        #5;
        miso_b = MISO;
        done_f = 1'b0;
        if (!CS && !rst && m_cnt < FN) begin
            m_word = {m_word[FS-2:0], mosi_b};
            m_started = 1'b1;
            m_bits++;
            if (m_bits == FS) begin
                done_f = 1'b1;
                m_bits = 0;
                m_cnt++;
            end
        end
        if (done_f) begin
            if (m_valid && !ack) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data = m_word;
        end else if (ack) begin
            m_valid = 1'b0;
        end
        SCLK = 1'b1;
        #5;
        SCLK = 1'b0;
    endtask

    // Shift nbits of a frame; ack optionally on first and/or final edge.
    task automatic xfer(input logic [FS-1:0] mosi_w, input logic [FS-1:0] tx_w,
                        input logic ack_first, input logic ack_last, input int nbits,
                        output logic [FS-1:0] miso_w);
        logic b;
        tx_data_i = tx_w;
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            clk_edge(mosi_w[FS-1-i], (i == 0 && ack_first) || (i == FS-1 && ack_last), b);
            miso_w[FS-1-i] = b;
        end
        rx_ack_i = 1'b0;
        #1;
    endtask

    task automatic cs_low();
        CS = 1'b0;
        #5;
    endtask

    task automatic cs_high();
        CS = 1'b1;
        m_bits = 0; m_cnt = 0; m_started = 1'b0;
        #5;
    endtask

    task automatic test_reset();
        rst = 1'b1; CS = 1'b0; tx_data_i = '1;
        #3;
        n_checks++; if (rx_data_o !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        n_checks++; if (frame_cnt_o !== '0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
        model_reset();
        rst = 1'b0; CS = 1'b1;
        #3;
        n_checks++; if (MISO !== MISO_REL) begin n_fail++; $display("FAIL cs_high_miso: got %b want %b", MISO, MISO_REL); end
    endtask

    // Single frame: MOSI 0xA5 in, 0x3C out, word lands on the 8th edge.
    task automatic test_basic();
        logic [FS-1:0] w;
        logic [FS-1:0] got;
        logic b;
        w = 8'hA5;
        tx_data_i = 8'h3C;
        cs_low();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy_o); end
        for (int i = 0; i < FS; i++) begin
            clk_edge(w[FS-1-i], 1'b0, b);
            got[FS-1-i] = b;
            if (i == FS - 2) begin
                #1;
                n_checks++; if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00) begin n_fail++; $display("FAIL basic_early: got valid %b data %h want 0 00", rx_valid_o, rx_data_o); end
                n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy_o); end
            end
        end
        #1;
        n_checks++; if (got !== 8'h3C) begin n_fail++; $display("FAIL basic_miso_word: got %h want 3c", got); end
        n_checks++; if (rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL basic_rx_data: got %h want a5", rx_data_o); end
        n_checks++; if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_rx_valid: got %b want 1", rx_valid_o); end
        n_checks++; if (frame_cnt_o !== FCS'(1)) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt_o); end
        cs_high();
        n_checks++; if (frame_cnt_o !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_cs_clear: got cnt %0d busy %b want 0 0", frame_cnt_o, busy_o); end
        n_checks++; if (MISO !== MISO_REL) begin n_fail++; $display("FAIL basic_cs_miso: got %b want %b", MISO, MISO_REL); end
        n_checks++; if (rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL basic_cs_keep: got %h want a5", rx_data_o); end
    endtask

    // Two acked frames reach DONE; further edges are ignored.
    task automatic test_done();
        logic [FS-1:0] tx;
        logic [FS-1:0] got;
        logic b;
        cs_low();
        tx = FS'($urandom);
        xfer(8'h12, tx, 1'b1, 1'b0, FS, got);
        n_checks++; if (got !== tx) begin n_fail++; $display("FAIL done_miso1: got %h want %h", got, tx); end
        n_checks++; if (frame_cnt_o !== FCS'(1) || busy_o !== 1'b1) begin n_fail++; $display("FAIL done_cnt1: got cnt %0d busy %b want 1 1", frame_cnt_o, busy_o); end
        tx = FS'($urandom);
        xfer(8'h34, tx, 1'b1, 1'b0, FS, got);
        n_checks++; if (got !== tx) begin n_fail++; $display("FAIL done_miso2: got %h want %h", got, tx); end
        n_checks++; if (frame_cnt_o !== FCS'(2) || busy_o !== 1'b0) begin n_fail++; $display("FAIL done_cnt2: got cnt %0d busy %b want 2 0", frame_cnt_o, busy_o); end
        n_checks++; if (rx_data_o !== 8'h34 || rx_valid_o !== 1'b1 || overrun_o !== 1'b0) begin n_fail++; $display("FAIL done_rx: got %h v%b o%b want 34 v1 o0", rx_data_o, rx_valid_o, overrun_o); end
        for (int i = 0; i < 9; i++) begin
            clk_edge(1'($urandom), 1'b0, b);
            n_checks++; if (b !== MISO_REL) begin n_fail++; $display("FAIL done_miso_edge%0d: got %b want %b", i, b, MISO_REL); end
        end
        #1;
        n_checks++; if (rx_data_o !== 8'h34 || frame_cnt_o !== FCS'(2)) begin n_fail++; $display("FAIL done_ignored: got %h cnt %0d want 34 cnt 2", rx_data_o, frame_cnt_o); end
        cs_high();
    endtask

    // Unacked words overwrite; ack coinciding with completion keeps valid.
    task automatic test_overrun();
        logic [FS-1:0] got;
        logic [FS-1:0] w;
        logic b;
        cs_low();
        xfer(8'h55, FS'($urandom), 1'b0, 1'b0, FS, got);
        xfer(8'hAA, FS'($urandom), 1'b0, 1'b0, FS, got);
        n_checks++; if (rx_data_o !== 8'hAA || overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %h o%b want aa o1", rx_data_o, overrun_o); end
        cs_high();
        cs_low();
        w = FS'($urandom);
        xfer(w, FS'($urandom), 1'b0, 1'b1, FS, got);
        n_checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== w) begin n_fail++; $display("FAIL ovr_ack_same_edge: got v%b %h want v1 %h", rx_valid_o, rx_data_o, w); end
        n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
        cs_high();
        clk_edge(1'b0, 1'b1, b);
        rx_ack_i = 1'b0;
        #1;
        n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b want 0", rx_valid_o); end
    endtask

    // CS released after four bits: nothing lands; the next frame is clean.
    task automatic test_abort();
        logic [FS-1:0] got;
        logic [FS-1:0] tx;
        logic [FS-1:0] prev;
        prev = m_data;
        cs_low();
        xfer(8'hF0, FS'($urandom), 1'b0, 1'b0, 4, got);
        cs_high();
        n_checks++; if (rx_data_o !== prev || rx_valid_o !== 1'b0 || frame_cnt_o !== '0) begin n_fail++; $display("FAIL abort_discard: got %h v%b cnt %0d want %h v0 cnt 0", rx_data_o, rx_valid_o, frame_cnt_o, prev); end
        cs_low();
        tx = FS'($urandom);
        xfer(8'h0F, tx, 1'b0, 1'b0, FS, got);
        n_checks++; if (rx_data_o !== 8'h0F || rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL abort_next: got %h v%b want 0f v1", rx_data_o, rx_valid_o); end
        n_checks++; if (got !== tx) begin n_fail++; $display("FAIL abort_miso: got %h want %h", got, tx); end
        cs_high();
    endtask

    // Reset mid-frame clears everything; next frame starts from its MSB.
    task automatic test_rst();
        logic [FS-1:0] got;
        logic [FS-1:0] tx;
        cs_low();
        xfer(FS'($urandom), FS'($urandom), 1'b0, 1'b0, 5, got);
        rst = 1'b1;
        #2;
        n_checks++; if (rx_data_o !== '0 || rx_valid_o !== 1'b0 || overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_rx: got %h v%b o%b want 00 v0 o0", rx_data_o, rx_valid_o, overrun_o); end
        n_checks++; if (frame_cnt_o !== '0 || busy_o !== 1'b0 || MISO !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got cnt %0d busy %b miso %b want 0 0 0", frame_cnt_o, busy_o, MISO); end
        model_reset();
        rst = 1'b0;
        #3;
        tx = FS'($urandom);
        xfer(8'h81, tx, 1'b0, 1'b0, FS, got);
        n_checks++; if (rx_data_o !== 8'h81 || rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_next: got %h v%b want 81 v1", rx_data_o, rx_valid_o); end
        n_checks++; if (got !== tx) begin n_fail++; $display("FAIL rst_miso: got %h want %h", got, tx); end
        cs_high();
    endtask

    // Random sessions of 1-3 frames, random acks, optional truncated last frame.
    task automatic test_random();
        logic [FS-1:0] got;
        logic [FS-1:0] tx;
        int nfr;
        int nb;
        logic live;
        for (int s = 0; s < 8; s++) begin
            cs_low();
            nfr = int'($urandom_range(3, 1));
            for (int f = 0; f < nfr; f++) begin
                nb = (f == nfr - 1 && $urandom_range(3, 0) == 0) ? int'($urandom_range(FS - 1, 1)) : FS;
                live = (m_cnt < FN);
                tx = FS'($urandom);
                xfer(FS'($urandom), tx, 1'($urandom), 1'($urandom), nb, got);
                n_checks++; if (rx_data_o !== m_data || rx_valid_o !== m_valid || overrun_o !== m_ovr) begin n_fail++; $display("FAIL rand_rx s%0d f%0d: got %h v%b o%b want %h v%b o%b", s, f, rx_data_o, rx_valid_o, overrun_o, m_data, m_valid, m_ovr); end
                n_checks++; if (frame_cnt_o !== FCS'(m_cnt) || busy_o !== (m_started && m_cnt < FN)) begin n_fail++; $display("FAIL rand_ctrl s%0d f%0d: got cnt %0d busy %b want %0d %b", s, f, frame_cnt_o, busy_o, m_cnt, m_started && m_cnt < FN); end
                if (live && nb == FS) begin
                    n_checks++; if (got !== tx) begin n_fail++; $display("FAIL rand_miso s%0d f%0d: got %h want %h", s, f, got, tx); end
                end
            end
            cs_high();
            n_checks++; if (frame_cnt_o !== '0 || MISO !== MISO_REL || rx_data_o !== m_data) begin n_fail++; $display("FAIL rand_end s%0d: got cnt %0d miso %b data %h want 0 %b %h", s, frame_cnt_o, MISO, rx_data_o, MISO_REL, m_data); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        SCLK = 1'b0; rst = 1'b0; CS = 1'b1; MOSI = 1'b0;
        rx_ack_i = 1'b0; tx_data_i = '0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_done();
        test_overrun();
        test_abort();
        test_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_slave
